// File: rtl/clipper_rr_if.sv
// FIFO-side bundles for the round-robin clipper.
// The clipper is master on both: it issues the read and write strobes.
interface clipper_rr_rd_if #(
    parameter int FLUX          = 2,
    parameter int DATA_WIDTH_IN = 16
);
    logic [FLUX-1:0]               empty;
    logic [FLUX*DATA_WIDTH_IN-1:0] dout;
    logic [FLUX-1:0]               read;

    modport master (input empty, input dout, output read);
    modport slave  (output empty, output dout, input read);
endinterface

interface clipper_rr_wr_if #(
    parameter int DIN_WIDTH = 9
);
    logic                 full;
    logic                 write;
    logic [DIN_WIDTH-1:0] din;

    modport master (input full, output write, output din);
    modport slave  (output full, input write, input din);
endinterface

// File: rtl/clipper_rr.sv
// Round-robin multi-flux saturating clipper feeding the pel output FIFO.
// One registered output slot; din = {flux tag, clipped sample}.
module clipper_rr #(
    parameter int FLUX           = 2,
    parameter int DATA_WIDTH_IN  = 16,
    parameter int DATA_WIDTH_OUT = 8,
    parameter int CLIP_MIN       = 0,
    parameter int CLIP_MAX       = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clipper_rr_rd_if.master      read_port_in_pel,
    clipper_rr_wr_if.master      write_port_out_pel,
    input  logic                 clip_cnt_clr,
    output logic [CNT_WIDTH-1:0] clip_cnt
);

    localparam int TW = (FLUX > 1) ? $clog2(FLUX) : 1;
    localparam int OW = TW + DATA_WIDTH_OUT;
    localparam int XW = DATA_WIDTH_IN + 1;

    localparam logic signed [XW-1:0] MIN_X = XW'(CLIP_MIN);
    localparam logic signed [XW-1:0] MAX_X = XW'(CLIP_MAX);
    localparam logic [DATA_WIDTH_OUT-1:0] MIN_O = DATA_WIDTH_OUT'(CLIP_MIN);
    localparam logic [DATA_WIDTH_OUT-1:0] MAX_O = DATA_WIDTH_OUT'(CLIP_MAX);
    localparam logic [TW-1:0] LAST_RST = TW'(FLUX - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT = {CNT_WIDTH{1'b1}};

    logic                      out_valid_q, out_valid_d;
    logic [OW-1:0]             out_data_q, out_data_d;
    logic [TW-1:0]             last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0]      clip_cnt_q, clip_cnt_d;

    logic [TW-1:0]             grant;
    logic                      any_nonempty;
    logic                      accept;
    logic                      pop;
    logic                      write;
    logic                      is_clip;
    logic [DATA_WIDTH_IN-1:0]  sample;
    logic signed [XW-1:0]      x;
    logic [DATA_WIDTH_OUT-1:0] clipped;

    assign write  = out_valid_q & ~write_port_out_pel.full;
    assign accept = ~out_valid_q | ~write_port_out_pel.full;
    // Gating with rst_n keeps read low while reset is asserted.
    assign pop    = rst_n & accept & any_nonempty;

    always_comb begin : arb
        int idx;
        grant        = '0;
        any_nonempty = 1'b0;
        idx          = 0;
        for (int k = 1; k <= FLUX; k++) begin
            idx = (int'(last_grant_q) + k) % FLUX;
            if (!any_nonempty && !read_port_in_pel.empty[idx]) begin
                any_nonempty = 1'b1;
                grant        = TW'(idx);
            end
        end
    end

    always_comb begin
        sample = read_port_in_pel.dout[int'(grant)*DATA_WIDTH_IN +: DATA_WIDTH_IN];
        x      = $signed({sample[DATA_WIDTH_IN-1], sample});
        is_clip = (x > MAX_X) || (x < MIN_X);
        if (x > MAX_X) begin
            clipped = MAX_O;
        end else if (x < MIN_X) begin
            clipped = MIN_O;
        end else begin
            clipped = x[DATA_WIDTH_OUT-1:0];
        end
    end

    always_comb begin
        read_port_in_pel.read = '0;
        for (int i = 0; i < FLUX; i++) begin
            read_port_in_pel.read[i] = pop && (grant == TW'(i));
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        last_grant_d = last_grant_q;
        clip_cnt_d   = clip_cnt_q;
        if (pop) begin
            out_valid_d  = 1'b1;
            out_data_d   = {grant, clipped};
            last_grant_d = grant;
        end else if (write) begin
            out_valid_d = 1'b0;
        end
        if (clip_cnt_clr) begin
            clip_cnt_d = '0;
        end else if (pop && is_clip && (clip_cnt_q != CNT_SAT)) begin
            clip_cnt_d = clip_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            last_grant_q <= LAST_RST;
            clip_cnt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            last_grant_q <= last_grant_d;
            clip_cnt_q   <= clip_cnt_d;
        end
    end

    assign write_port_out_pel.write = write;
    assign write_port_out_pel.din   = out_data_q;
    assign clip_cnt                 = clip_cnt_q;

endmodule

// File: tb/tb_clipper_rr.sv
// Scoreboard bench for clipper_rr: a default 2-flux instance and
// a 4-flux [16,235] instance with a 4-bit clip counter.
module tb_clipper_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_na, rst_nb, clr_a, clr_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    clipper_rr_rd_if #(.FLUX(2), .DATA_WIDTH_IN(16)) ra();
    clipper_rr_wr_if #(.DIN_WIDTH(9))                wa();
    clipper_rr_rd_if #(.FLUX(4), .DATA_WIDTH_IN(16)) rb();
    clipper_rr_wr_if #(.DIN_WIDTH(10))               wb();

    clipper_rr #(.FLUX(2)) dut_a (
        .clk                (clk),
        .rst_n              (rst_na),
        .read_port_in_pel   (ra),
        .write_port_out_pel (wa),
        .clip_cnt_clr       (clr_a),
        .clip_cnt           (cnt_a)
    );

    clipper_rr #(
        .FLUX(4), .CLIP_MIN(16), .CLIP_MAX(235), .CNT_WIDTH(4)
    ) dut_b (
        .clk                (clk),
        .rst_n              (rst_nb),
        .read_port_in_pel   (rb),
        .write_port_out_pel (wb),
        .clip_cnt_clr       (clr_b),
        .clip_cnt           (cnt_b)
    );

    int qa[$];
    int qb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (wa.write === 1'b1) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_extra_write: got %0h want none", wa.din);
            end else begin
                chk("a_din", 32'(wa.din), qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (wb.write === 1'b1) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_extra_write: got %0h want none", wb.din);
            end else begin
                chk("b_din", 32'(wb.din), qb.pop_front());
            end
        end
    end

    initial begin
        int expb[4];
        expb[0] = 'h010;
        expb[1] = 'h1EB;
        expb[2] = 'h210;
        expb[3] = 'h3EB;

        rst_na = 1'b0; rst_nb = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        ra.empty = '0; ra.dout = '0; wa.full = 1'b0;
        rb.empty = '1; rb.dout = '0; wb.full = 1'b0;
        #12;
        chk("a_rst_read", ra.read, 0);
        chk("a_rst_write", wa.write, 0);
        chk("a_rst_din", wa.din, 0);
        chk("a_rst_cnt", cnt_a, 0);
        chk("b_rst_cnt", cnt_b, 0);
        ra.empty = '1;
        @(negedge clk);
        rst_na = 1'b1;
        rst_nb = 1'b1;
        cyc();

        // Both fluxes: 300 -> 255, -5 -> 0
        ra.dout  = {16'hFFFB, 16'd300};
        ra.empty = 2'b00;
        qa.push_back('h0FF);
        qa.push_back('h100);
        #1;
        chk("t1_read0", ra.read, 2'b01);
        cyc();
        chk("t1_read1", ra.read, 2'b10);
        cyc();
        ra.empty = '1;
        cyc(2);
        chk("t1_cnt", cnt_a, 2);

        // Backpressure with flux 0 kept non-empty
        wa.full  = 1'b1;
        ra.dout[15:0] = 16'd128;
        ra.empty = 2'b10;
        qa.push_back('h080);
        #1;
        chk("t2_read", ra.read, 2'b01);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_read", ra.read, 0);
            chk("t2_hold_write", wa.write, 0);
            chk("t2_hold_din", wa.din, 'h080);
            if (i < 2) cyc();
        end
        wa.full  = 1'b0;
        ra.empty = '1;
        #1;
        chk("t2_drain_write", wa.write, 1);
        cyc();

        // Idle, then one flux-1 sample of 0x7FFF
        for (int i = 0; i < 3; i++) begin
            chk("t3_idle_read", ra.read, 0);
            chk("t3_idle_write", wa.write, 0);
            cyc();
        end
        ra.dout[31:16] = 16'h7FFF;
        ra.empty = 2'b01;
        qa.push_back('h1FF);
        #1;
        chk("t3_read", ra.read, 2'b10);
        cyc();
        ra.empty = '1;
        cyc();
        chk("t3_cnt", cnt_a, 3);

        clr_a = 1'b1;
        cyc();
        clr_a = 1'b0;
        chk("t4_clr", cnt_a, 0);

        // Async reset while a sample is held and flux 1 is due next
        ra.dout[15:0] = 16'd5;
        ra.empty = 2'b10;
        #1;
        chk("t5_read0", ra.read, 2'b01);
        cyc();
        ra.empty = 2'b00;
        #1;
        chk("t5_pre_write", wa.write, 1);
        chk("t5_pre_read", ra.read, 2'b10);
        rst_na = 1'b0;
        #1;
        chk("t5_rst_write", wa.write, 0);
        chk("t5_rst_read", ra.read, 0);
        chk("t5_rst_din", wa.din, 0);
        @(negedge clk);
        @(negedge clk);
        rst_na  = 1'b1;
        ra.dout = {16'd9, 16'd7};
        qa.push_back('h007);
        qa.push_back('h109);
        #1;
        chk("t5_first_grant", ra.read, 2'b01);
        @(posedge clk);
        #1;
        chk("t5_second_grant", ra.read, 2'b10);
        cyc();
        ra.empty = '1;
        cyc(2);

        // Four-flux fairness with samples at and beyond the bounds
        rb.dout  = {16'd236, 16'd15, 16'd235, 16'd16};
        rb.empty = 4'b0000;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("b_rr_read", rb.read, 32'd1 << (k % 4));
            qb.push_back(expb[k % 4]);
            cyc();
        end
        rb.empty = '1;
        chk("b_rr_cnt", cnt_b, 4);

        // Saturate the 4-bit counter with flux 2 (15 -> 16)
        rb.empty = 4'b1011;
        #1;
        chk("b_sat_read", rb.read, 4'b0100);
        repeat (20) begin
            qb.push_back('h210);
            cyc();
        end
        chk("b_sat_cnt", cnt_b, 15);
        clr_b = 1'b1;
        qb.push_back('h210);
        cyc();
        clr_b = 1'b0;
        chk("b_clr_pri", cnt_b, 0);
        qb.push_back('h210);
        cyc();
        rb.empty = '1;
        chk("b_after_clr", cnt_b, 1);

        // Negative sample on flux 0, in-range sample on flux 1
        rb.dout[15:0] = 16'hFF9C;
        rb.empty = 4'b1110;
        qb.push_back('h010);
        cyc();
        rb.dout[31:16] = 16'd100;
        rb.empty = 4'b1101;
        qb.push_back('h164);
        cyc();
        rb.empty = '1;
        cyc();
        chk("b_final_cnt", cnt_b, 2);

        cyc(3);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clipper_rr.md
Name: clipper_rr

Overview:
- Parametrised multi-flux saturating clipper placed between the inverse-transform residual-add stage and the pel output FIFO.
- Each cycle it selects one non-empty input flux by round-robin and clips the signed sample to [CLIP_MIN, CLIP_MAX].
- The clipped sample is registered, tagged with its flux index, and written out.
- A saturating counter reports how many samples were clipped.

Parameters:
- FLUX, 2: number of input fluxes/channels (>=1).
- DATA_WIDTH_IN, 16: input sample width, two's complement.
- DATA_WIDTH_OUT, 8: output sample width, unsigned.
- CLIP_MIN, 0: lower clip bound, integer.
- CLIP_MAX, 255: upper clip bound; must satisfy CLIP_MIN <= CLIP_MAX <= 2^DATA_WIDTH_OUT-1.
- CNT_WIDTH, 16: width of the clip-event counter.
- TAG_WIDTH, derived: max($clog2(FLUX),1).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- read_port_in_pel.empty, input, FLUX: per-flux empty flag (read_interface.actor).
- read_port_in_pel.dout, input, FLUX*DATA_WIDTH_IN: flux i occupies [i*DATA_WIDTH_IN +: DATA_WIDTH_IN].
- read_port_in_pel.read, output, FLUX: one-hot pop strobe.
- write_port_out_pel.full, input, 1: output FIFO full (write_interface.actor).
- write_port_out_pel.write, output, 1: push strobe.
- write_port_out_pel.din, output, TAG_WIDTH+DATA_WIDTH_OUT: {tag, clipped sample}.
- clip_cnt_clr, input, 1: synchronous clear of clip_cnt.
- clip_cnt, output, CNT_WIDTH: number of samples clipped, saturating.

Behaviour:
- State:
  - out_valid: 1-entry output register flag.
  - out_data: output register, TAG_WIDTH+DATA_WIDTH_OUT.
  - last_grant: TAG_WIDTH.
  - clip_cnt: CNT_WIDTH.
- Reset values (async, while rst_n=0):
  - out_valid=0, out_data=0, last_grant=FLUX-1 (so flux 0 wins first), clip_cnt=0.
  - Outputs during reset: write=0, read=0, din=0.
- Output side, combinational:
  - write = out_valid & !full.
  - din = out_data at all times, stable while out_valid & full.
- Accept:
  - accept = !out_valid | !full. The register can load in the same cycle it drains, so sustained throughput is 1 sample/cycle.
- Arbitration:
  - Search flux indices last_grant+1, last_grant+2, ... modulo FLUX and take the first with empty[i]=0 as grant.
  - If no flux is non-empty, there is no grant.
- Read:
  - read[grant] = accept & any_nonempty; every other read bit is 0.
  - read is never asserted for an empty flux.
- On a pop (rising edge where read != 0):
  - out_data <= {grant, clip(dout[grant])}.
  - out_valid <= 1.
  - last_grant <= grant.
- Without a pop:
  - If write=1 then out_valid <= 0; otherwise out_valid is held.
  - last_grant is held.
- Latency: input pop to output write is 1 cycle when full=0.
- Clip arithmetic:
  - Compare signed on DATA_WIDTH_IN+1 bits.
  - x > CLIP_MAX gives CLIP_MAX; x < CLIP_MIN gives CLIP_MIN; otherwise x[DATA_WIDTH_OUT-1:0].
  - Values equal to a bound are not counted as clipped.
- clip_cnt:
  - Increments by 1 on each pop whose sample was clipped.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - clip_cnt_clr has priority: if clear and a clipped pop happen in the same cycle, the result is 0.
- Fairness: with all fluxes continuously non-empty and no backpressure, grants rotate 0,1,...,FLUX-1,0,...
- FLUX=1: tag is a constant 0 of width 1; arbitration degenerates to a single flux.
- Reset mid-operation: the registered sample is discarded, no write is issued, and arbitration restarts at flux 0.

Test Plan:
- FLUX=2, both non-empty, dout0=300, dout1=-5, full=0 → din={0,255} then {1,0} on consecutive cycles; clip_cnt=2.
- Flux 0 only, sample 128, full=1 for 3 cycles then 0:
  - read0 pulses once; write stays 0 while full=1 and din holds {0,128}.
  - write=1 on the first cycle with full=0; no second read occurs before the drain cycle.
- FLUX=4, CLIP_MIN=16, CLIP_MAX=235, all non-empty for 8 cycles, samples 16/235/15/236 → tags 0,1,2,3,0,1,2,3; outputs 16,235,16,235; clip_cnt increments only for 15 and 236.
- CNT_WIDTH=4, 20 clipped samples → clip_cnt sticks at 15; clip_cnt_clr coinciding with a clipped pop → 0.
- rst_n dropped asynchronously while out_valid=1 → write/read drop immediately; after release the first grant goes to flux 0 even if last_grant was 0.
- All empty → read=0, write=0 forever; a single flux 1 sample of 0x7FFF → din={1,255}.
